// File: rtl/iter_mult_if.sv
// Request/response bundle for the iterative multiplier.
// The module drives product/done/busy. The requester drives the rest.
interface iter_mult_if #(
    parameter int WIDTH = 64
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   product;
    logic                 done;
    logic                 busy;

    modport master (
        output start, signed_mode, mcand, mplier,
        input  product, done, busy
    );

    modport slave (
        input  start, signed_mode, mcand, mplier,
        output product, done, busy
    );
endinterface

// File: rtl/iter_mult.sv
// Iterative multiplier: retires RADIX_BITS multiplier bits per cycle, N = WIDTH/RADIX_BITS cycles.
// Supports unsigned and two's-complement operation, and registers the full 2*WIDTH product.
module iter_mult #(
    parameter int WIDTH      = 64,
    parameter int RADIX_BITS = 8
) (
    input logic        clock,
    input logic        reset,
    iter_mult_if.slave bus
);
    localparam int N     = WIDTH / RADIX_BITS;
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("iter_mult: WIDTH must be at least 2");
    end
    if (WIDTH % RADIX_BITS != 0) begin : g_bad_radix
        $error("iter_mult: WIDTH must be a multiple of RADIX_BITS");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic                  last;
    logic [CNT_W-1:0]      count;
    logic                  signed_q;
    logic [PW-1:0]         mcand_sh;
    logic [WIDTH-1:0]      mplier_sh;
    logic [PW-1:0]         acc;
    logic [PW-1:0]         acc_next;
    logic [PW-1:0]         product_q;
    logic                  done_q;
    logic                  busy_q;
    logic [RADIX_BITS-1:0] slice;
    logic                  slice_neg;
    logic [PW-1:0]         slice_wide;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                last = (count == CNT_W'(N - 1));
                if (last) next_state = DONE;
            end
            default: next_state = IDLE;
        endcase
    end

    // In signed mode the top slice carries the multiplier's negative MSB weight, so it
    // is sign-extended. All lower slices are unsigned digits. mcand is pre-extended to PW.
    always_comb begin
        slice      = mplier_sh[RADIX_BITS-1:0];
        slice_neg  = signed_q & last & slice[RADIX_BITS-1];
        slice_wide = {{(PW - RADIX_BITS){slice_neg}}, slice};
        acc_next   = acc + mcand_sh * slice_wide;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count     <= '0;
            signed_q  <= 1'b0;
            mcand_sh  <= '0;
            mplier_sh <= '0;
            acc       <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            if (accept) begin
                mcand_sh  <= bus.signed_mode ? {{WIDTH{bus.mcand[WIDTH-1]}}, bus.mcand}
                                             : {{WIDTH{1'b0}}, bus.mcand};
                mplier_sh <= bus.mplier;
                signed_q  <= bus.signed_mode;
                acc       <= '0;
                count     <= '0;
            end else if (state == BUSY) begin
                acc       <= acc_next;
                mcand_sh  <= mcand_sh << RADIX_BITS;
                mplier_sh <= mplier_sh >> RADIX_BITS;
                count     <= count + CNT_W'(1);
                if (last) product_q <= acc_next;
            end
            busy_q <= (next_state == BUSY);
            done_q <= (next_state == DONE);
        end
    end

    assign bus.product = product_q;
    assign bus.done    = done_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_iter_mult.sv
// Directed and table-driven checks of iter_mult at three configurations:
// 64/8 (main), 16/1 (back-to-back random vs reference) and 32/32 (single-cycle).
module tb_iter_mult;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iter_mult_if #(.WIDTH(64)) b64 ();
    iter_mult_if #(.WIDTH(16)) b16 ();
    iter_mult_if #(.WIDTH(32)) b32 ();

    iter_mult #(.WIDTH(64), .RADIX_BITS(8))  dut64 (.clock(clk), .reset(rst), .bus(b64));
    iter_mult #(.WIDTH(16), .RADIX_BITS(1))  dut16 (.clock(clk), .reset(rst), .bus(b16));
    iter_mult #(.WIDTH(32), .RADIX_BITS(32)) dut32 (.clock(clk), .reset(rst), .bus(b32));

    typedef struct {
        logic         s;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
    } vec_t;

    vec_t         vecs[13];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [127:0] last_p   = '0;
    logic [63:0]  last32   = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a negedge; returns just after the negedge following completion.
    task automatic op64(input logic s, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] p, input string name);
        b64.start = 1'b1; b64.signed_mode = s; b64.mcand = a; b64.mplier = b;
        @(negedge clk);
        b64.start = 1'b0; b64.signed_mode = ~s;
        b64.mcand = {$urandom, $urandom}; b64.mplier = {$urandom, $urandom};
        for (int i = 0; i < 8; i++) begin
            check({name, " busy/done"}, 128'({b64.busy, b64.done}), 128'(2'b10));
            check({name, " held"}, b64.product, last_p);
            @(negedge clk);
        end
        check({name, " busy/done end"}, 128'({b64.busy, b64.done}), 128'(2'b01));
        check({name, " product"}, b64.product, p);
        last_p = p;
    endtask

    task automatic op32(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] p, input string name);
        b32.start = 1'b1; b32.signed_mode = s; b32.mcand = a; b32.mplier = b;
        @(negedge clk);
        b32.start = 1'b0; b32.mcand = $urandom; b32.mplier = $urandom;
        check({name, " busy/done"}, 128'({b32.busy, b32.done}), 128'(2'b10));
        check({name, " held"}, 128'(b32.product), 128'(last32));
        @(negedge clk);
        check({name, " busy/done end"}, 128'({b32.busy, b32.done}), 128'(2'b01));
        check({name, " product"}, 128'(b32.product), 128'(p));
        last32 = p;
    endtask

    initial begin
        logic [15:0] cur_a, cur_b, nxt_a, nxt_b;
        logic        cur_s, nxt_s, early;
        logic [31:0] exp16;

        vecs[0]  = '{1'b0, 64'd2, 64'd3, 128'd6};
        vecs[1]  = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                     128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        vecs[2]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFEC, 64'd5,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF9C};
        vecs[3]  = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[4]  = '{1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     128'h4000_0000_0000_0000_0000_0000_0000_0000};
        vecs[5]  = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};
        vecs[6]  = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                     128'hC000_0000_0000_0000_8000_0000_0000_0000};
        vecs[7]  = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                     128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
        vecs[8]  = '{1'b0, 64'h1234_5678_9ABC_DEF0, 64'h10,
                     128'h0000_0000_0000_0001_2345_6789_ABCD_EF00};
        vecs[9]  = '{1'b1, 64'd3, 64'hFFFF_FFFF_FFFF_FFF9,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB};
        vecs[10] = '{1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     128'h0000_0000_0000_0000_8000_0000_0000_0000};
        vecs[11] = '{1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     128'h7FFF_FFFF_FFFF_FFFF_8000_0000_0000_0000};
        vecs[12] = '{1'b1, 64'd5, 64'hFFFF_FFFF_FFFF_FFEC,
                     128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF9C};

        b64.start = 1'b0; b64.signed_mode = 1'b0; b64.mcand = '0; b64.mplier = '0;
        b16.start = 1'b0; b16.signed_mode = 1'b0; b16.mcand = '0; b16.mplier = '0;
        b32.start = 1'b0; b32.signed_mode = 1'b0; b32.mcand = '0; b32.mplier = '0;

        // Reset for 4 cycles; start raised in the last reset cycle must be ignored.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                b64.start = 1'b1; b64.mcand = 64'd9; b64.mplier = 64'd9;
            end
            @(negedge clk);
            check("reset outputs", {b64.product, b64.done, b64.busy}, '0);
        end
        rst = 1'b0; b64.start = 1'b0;
        @(negedge clk);
        check("idle after reset", {b64.product, b64.done, b64.busy}, '0);

        for (int v = 0; v < 13; v++)
            op64(vecs[v].s, vecs[v].a, vecs[v].b, vecs[v].p, $sformatf("vec%0d", v));

        // start held through every BUSY cycle with changing operands, including the last.
        b64.start = 1'b1; b64.signed_mode = 1'b0; b64.mcand = 64'd11; b64.mplier = 64'd13;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("busy-start busy/done", 128'({b64.busy, b64.done}), 128'(2'b10));
            check("busy-start held", b64.product, last_p);
            b64.start = 1'b1; b64.signed_mode = 1'($urandom);
            b64.mcand = {$urandom, $urandom}; b64.mplier = {$urandom, $urandom};
            @(negedge clk);
        end
        b64.start = 1'b0;
        check("busy-start done", 128'({b64.busy, b64.done}), 128'(2'b01));
        check("busy-start product", b64.product, 128'd143);
        @(negedge clk);
        check("done hold", 128'({b64.busy, b64.done}), 128'(2'b01));
        check("done hold product", b64.product, 128'd143);
        last_p = 128'd143;

        // Reset in the 4th BUSY cycle discards the operation.
        b64.start = 1'b1; b64.mcand = 64'd5; b64.mplier = 64'd5;
        @(negedge clk);
        b64.start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", 128'(b64.busy), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("mid-busy reset", {b64.product, b64.done, b64.busy}, '0);
        rst = 1'b0; last_p = '0; last32 = '0;
        op64(1'b0, 64'd7, 64'd9, 128'd63, "post-reset");

        op32(1'b0, 32'd0, 32'hDEAD_BEEF, 64'd0, "n1 zero");
        op32(1'b0, 32'd2, 32'hDEAD_BEEF, 64'h0000_0001_BD5B_7DDE, "n1 unsigned");
        op32(1'b1, 32'd2, 32'hDEAD_BEEF, 64'hFFFF_FFFF_BD5B_7DDE, "n1 signed");

        // Radix-1 16-bit: start held continuously, one result every 17 edges.
        cur_a = 16'($urandom); cur_b = 16'($urandom); cur_s = 1'b0;
        b16.start = 1'b1; b16.signed_mode = cur_s; b16.mcand = cur_a; b16.mplier = cur_b;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check("r16 accept", 128'({b16.busy, b16.done}), 128'(2'b10));
            exp16 = cur_s ? 32'($signed(cur_a)) * 32'($signed(cur_b))
                          : 32'(cur_a) * 32'(cur_b);
            nxt_a = 16'($urandom); nxt_b = 16'($urandom); nxt_s = (i + 1 >= 500);
            b16.signed_mode = nxt_s; b16.mcand = nxt_a; b16.mplier = nxt_b;
            early = 1'b0;
            for (int j = 1; j <= 16; j++) begin
                @(negedge clk);
                if (j < 16 && b16.done) early = 1'b1;
            end
            check($sformatf("r16 op%0d", i), 128'({early, b16.done, b16.product}),
                  128'({1'b0, 1'b1, exp16}));
            cur_a = nxt_a; cur_b = nxt_b; cur_s = nxt_s;
        end
        b16.start = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
